// File: rtl/mp_add_pkg.sv
// Shared constants and types for the multi-precision add sequencer.
package mp_add_pkg;

    localparam int LIMB_W = 32;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mp_state_t;

endpackage

// File: rtl/prefix_adder.sv
// 32-bit parallel-prefix (Kogge-Stone) adder with carry-in and carry-out.
module prefix_adder
    import mp_add_pkg::*;
(
    input  logic [LIMB_W-1:0] A,
    input  logic [LIMB_W-1:0] B,
    input  logic              Cin,
    output logic [LIMB_W-1:0] Sum,
    output logic              Cout
);

    // Bit 0 of the prefix tree carries Cin as a pure generate term.
    localparam int NBITS  = LIMB_W + 1;
    localparam int LEVELS = $clog2(NBITS);

    logic [NBITS-1:0] gl [0:LEVELS];
    logic [NBITS-1:0] pl [0:LEVELS-1];

    always_comb begin
        for (int l = 0; l <= LEVELS; l++) begin
            gl[l] = '0;
        end
        for (int l = 0; l < LEVELS; l++) begin
            pl[l] = '0;
        end
        gl[0] = {A & B, Cin};
        pl[0] = {A ^ B, 1'b0};
        for (int l = 1; l < LEVELS; l++) begin
            for (int i = 0; i < NBITS; i++) begin
                if (i >= (1 << (l - 1))) begin
                    pl[l][i] = pl[l-1][i] & pl[l-1][i - (1 << (l - 1))];
                end else begin
                    pl[l][i] = pl[l-1][i];
                end
            end
        end
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < NBITS; i++) begin
                if (i >= (1 << l)) begin
                    gl[l+1][i] = gl[l][i] | (pl[l][i] & gl[l][i - (1 << l)]);
                end else begin
                    gl[l+1][i] = gl[l][i];
                end
            end
        end
    end

    // gl[LEVELS][i] is the carry into operand bit i.
    assign Sum  = pl[0][NBITS-1:1] ^ gl[LEVELS][NBITS-2:0];
    assign Cout = gl[LEVELS][NBITS-1];

endmodule

// File: rtl/mp_add_sequencer.sv
// Wide add built from one 32-bit prefix adder, one limb per cycle LSB first,
// with valid/ready handshakes on operand input and registered result output.
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LIMB_W*WORDS-1:0] in_a,
    input  logic [LIMB_W*WORDS-1:0] in_b,
    input  logic                    in_cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LIMB_W*WORDS-1:0] out_sum,
    output logic                    out_cout
);

    localparam int                 W        = LIMB_W * WORDS;
    localparam int                 IDX_W    = $clog2(WORDS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WORDS - 1);

    mp_state_t        state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [LIMB_W-1:0] limb_a;
    logic [LIMB_W-1:0] limb_b;
    logic [LIMB_W-1:0] add_sum;
    logic              add_cout;

    assign limb_a = a_q[idx_q*LIMB_W +: LIMB_W];
    assign limb_b = b_q[idx_q*LIMB_W +: LIMB_W];

    prefix_adder u_prefix_adder (
        .A    (limb_a),
        .B    (limb_b),
        .Cin  (carry_q),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*LIMB_W +: LIMB_W] = add_sum;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    // idx stays put on the last limb so it never wraps.
                    cout_d  = add_cout;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Randomized and directed checks of mp_add_sequencer against a plain wide-add model.
module tb_mp_add_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_cin    = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_sum;
    logic         out_cout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W:0] exp_q = '0;

    mp_add_sequencer #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [W:0] got, input logic [W:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, expv);
        end
    endtask

    function automatic logic [W:0] zb(input logic x);
        return {{W{1'b0}}, x};
    endfunction

    function automatic logic [W:0] zi(input int v);
        return {{(W-31){1'b0}}, 32'(v)};
    endfunction

    // Reference: the whole operation is one wide addition.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        return {1'b0, a} + {1'b0, b} + zb(cin);
    endfunction

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++) begin
            case ($urandom_range(0, 3))
                0:       v[i*32 +: 32] = 32'hFFFF_FFFF;
                1:       v[i*32 +: 32] = 32'h0;
                default: v[i*32 +: 32] = $urandom;
            endcase
        end
        return v;
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        int cnt = 0;
        while (!in_ready && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check_eq("in_ready_before_accept", zb(in_ready), zb(1'b1));
        exp_q    = ref_add(a, b, cin);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        in_cin   = ~cin;
        check_eq("in_ready_drop", zb(in_ready), zb(1'b0));
    endtask

    task automatic wait_done(input string tag);
        int cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        check_eq({tag, "_latency"}, zi(cnt), zi(WORDS));
        check_eq({tag, "_result"}, {out_cout, out_sum}, exp_q);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("valid_drop", zb(out_valid), zb(1'b0));
        check_eq("ready_back", zb(in_ready), zb(1'b1));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin);
        start_op(a, b, cin);
        wait_done(tag);
        drain();
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] a2;
        logic [W-1:0] b2;
        logic         c2;
        ones = '1;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", zb(in_ready), zb(1'b1));
        check_eq("rst_out_valid", zb(out_valid), zb(1'b0));
        check_eq("rst_result", {out_cout, out_sum}, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("basic", W'(1), W'(1), 1'b0);
        run_op("full_ripple", ones, W'(1), 1'b0);
        run_op("limb_boundary", W'(64'h0000FFFF_FFFFFFFF), W'(1), 1'b1);
        run_op("saturation", ones, ones, 1'b1);

        // Backpressure: result held, new operands ignored until after the transfer.
        start_op(rand_operand(), rand_operand(), 1'($urandom));
        wait_done("bp");
        a2       = rand_operand();
        b2       = rand_operand();
        c2       = 1'($urandom);
        in_a     = a2;
        in_b     = b2;
        in_cin   = c2;
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check_eq("bp_hold_result", {out_cout, out_sum}, exp_q);
            check_eq("bp_hold_valid", zb(out_valid), zb(1'b1));
            check_eq("bp_in_ready", zb(in_ready), zb(1'b0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("bp_not_same_edge", zb(in_ready), zb(1'b1));
        check_eq("bp_valid_drop", zb(out_valid), zb(1'b0));
        exp_q = ref_add(a2, b2, c2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("bp_new_accepted", zb(in_ready), zb(1'b0));
        wait_done("bp_next");
        drain();

        // Reset in the middle of RUN, with a nonzero previous result in the registers.
        start_op(rand_operand() | W'(1), rand_operand(), 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_in_ready", zb(in_ready), zb(1'b1));
        check_eq("midrst_out_valid", zb(out_valid), zb(1'b0));
        check_eq("midrst_result", {out_cout, out_sum}, '0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_still_idle", zb(out_valid), zb(1'b0));
        run_op("after_reset", W'(5), W'(7), 1'b0);

        for (int k = 0; k < 30; k++) begin
            int holds;
            start_op(rand_operand(), rand_operand(), 1'($urandom));
            wait_done("random");
            holds = $urandom_range(0, 3);
            for (int h = 0; h < holds; h++) begin
                @(posedge clk); #1;
                check_eq("random_hold", {out_cout, out_sum}, exp_q);
            end
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mp_add_sequencer.md
# mp_add_sequencer

Multi-precision add sequencer that sits directly in front of the existing 32-bit `prefix_adder` and consumes its output. It accepts a wide operand pair through a valid/ready handshake. It feeds one 32-bit limb per cycle, LSB limb first, into `prefix_adder`, chaining the adder's `Cout` into the next limb's `Cin`. It collects the `Sum` limbs into a registered wide result, which it presents through an output valid/ready handshake.

## Interface
Parameters:
- `WORDS`, default 4: number of 32-bit limbs. Operand width is `32*WORDS`. Legal range is 2..16.

Ports:
- `clk`, input, 1: single clock. Rising-edge triggered.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: operand pair valid.
- `in_ready`, output, 1: block can accept an operand pair.
- `in_a`, input, 32*WORDS: operand A.
- `in_b`, input, 32*WORDS: operand B.
- `in_cin`, input, 1: carry-in to limb 0.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_sum`, output, 32*WORDS: registered sum.
- `out_cout`, output, 1: carry-out of the top limb.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - RUN: processes limbs.
  - DONE: `out_valid`=1.
- IDLE → RUN on `in_valid`. Same edge:
  - latch `in_a`, `in_b` into operand registers
  - `carry` ← `in_cin`
  - `idx` ← 0
- RUN, each cycle:
  - `prefix_adder` inputs: A = limb `idx` of latched A, B = limb `idx` of latched B, Cin = `carry`.
  - At the edge: result limb `idx` ← `Sum`, `carry` ← `Cout`, `idx` ← `idx`+1.
- RUN → DONE on the edge that processes `idx`=`WORDS`-1. That edge also makes `out_cout` ← that limb's `Cout`.
- DONE → IDLE when `out_ready`=1.
- `in_ready` is high only in IDLE. Operands presented in RUN or DONE are not accepted and are not consumed.
- `out_sum` and `out_cout` are driven directly from registers. They are held stable for the whole of DONE, including under backpressure.
- Result limbs not yet written in the current operation hold their previous values. Consumers sample outputs only while `out_valid`=1.
- Arithmetic is modulo 2^(32*WORDS) with carry-out. There is no overflow or signed interpretation.
- `idx` width is `$clog2(WORDS)`. `idx` never wraps within an operation.

## Timing
- Reset values:
  - state = IDLE, so `in_ready`=1 and `out_valid`=0.
  - `out_sum`=0, `out_cout`=0.
  - `carry`=0, `idx`=0.
  - operand registers = 0.
- Reset is asynchronous. Asserting `rst_n` low mid-RUN or mid-DONE aborts the operation immediately and returns the block to the reset values. No partial result is ever flagged valid.
- Latency: an input accepted at edge N gives `out_valid`=1 after edge N+`WORDS`.
- Throughput: at most one operation every `WORDS`+2 cycles, with `out_ready` held high.
- Handshakes:
  - A transfer occurs on an edge where valid=1 and ready=1.
  - `out_valid`, once high, stays high until the transfer.
  - `in_ready` deasserts on the edge after acceptance.
- Simultaneous `out_ready`=1 in DONE and `in_valid`=1: the block returns to IDLE first. The new operand is accepted on a following edge, not the same one.
- The combinational path within one RUN cycle is: operand register → `prefix_adder` → result/carry register. The limb mux must not add more than a `WORDS`:1 mux level.

## Structure
- Package `mp_add_pkg`:
  - `localparam LIMB_W = 32`.
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} mp_state_t`.
- Sub-module: one instance of the existing `prefix_adder`, ports `A`, `B`, `Cin`, `Sum`, `Cout`. It is the only arithmetic in the block.
- The operand and result registers are flat `32*WORDS` vectors, indexed by `idx*LIMB_W +: LIMB_W`.

## Test plan
All scenarios use `WORDS`=4.
- **Basic:** A=1, B=1, cin=0 → `out_sum`=2, `out_cout`=0. `out_valid` rises exactly 4 edges after acceptance.
- **Full ripple:** A=2^128-1, B=1, cin=0 → `out_sum`=0, `out_cout`=1. The carry must propagate through all 4 limbs.
- **Limb boundary:** A=0x0000FFFF_FFFFFFFF, B=1, cin=1 → `out_sum`=0x00010000_00000001, `out_cout`=0.
- **Saturation:** A=B=2^128-1, cin=1 → `out_sum`=2^128-1, `out_cout`=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE. Required:
  - `out_sum` and `out_cout` stable
  - `in_ready`=0
  - a new `in_valid` is ignored until after the output transfer.
- **Reset mid-RUN:** pulse `rst_n` low at `idx`=2 → outputs return to reset values immediately and `in_ready`=1. A following operation (A=5, B=7) gives 12.
